// File: rtl/streammult_pkg.sv
// Shared types for the stream multiplier traffic generator / checker.
package streammult_pkg;

  localparam int OPW   = 16;
  localparam int PRODW = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic                    last;
    logic signed [PRODW-1:0] prod;
  } exp_t;

  // Low PRODW bits of the sign-extended product equal the full signed result.
  function automatic logic signed [PRODW-1:0] smul(
    input logic signed [OPW-1:0] a,
    input logic signed [OPW-1:0] b
  );
    logic [PRODW-1:0] ax;
    logic [PRODW-1:0] bx;
    ax = {{(PRODW-OPW){a[OPW-1]}}, a};
    bx = {{(PRODW-OPW){b[OPW-1]}}, b};
    return ax * bx;
  endfunction

endpackage

// File: rtl/streammult_exp_fifo.sv
// Expected-result FIFO, first-word-fall-through, wrap-bit pointers.
module streammult_exp_fifo
  import streammult_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  exp_t din,
  output exp_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  exp_t        mem_q [DEPTH];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push && !full)
      wr_d = wr_q + {{AW{1'b0}}, 1'b1};
    if (pop && !empty)
      rd_d = rd_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/streammult_tester.sv
// AXI-Stream operand generator and product checker for the stream
// multiplier; drives its slave port and checks its master port.
module streammult_tester
  import streammult_pkg::*;
#(
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int PKT_LEN                = 8,
  parameter int FIFO_DEPTH             = 4
) (
  input  logic                              axis_aclk,
  input  logic                              axis_areset,
  input  logic                              start,
  input  logic [15:0]                       num_pkts,
  input  logic [15:0]                       base_a,
  input  logic [15:0]                       base_b,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [15:0]                       err_count,
  output logic                              m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready,
  input  logic                              s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready
);

  state_e                state_q, state_d;
  logic signed [OPW-1:0] a_q, a_d;
  logic signed [OPW-1:0] b_q, b_d;
  logic                  last_q, last_d;
  logic [15:0]           beat_q, beat_d;
  logic [15:0]           pkt_q, pkt_d;
  logic [15:0]           npkts_q, npkts_d;
  logic [15:0]           err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;

  logic fifo_full;
  logic fifo_empty;
  exp_t push_din;
  exp_t head;
  logic m_hs;
  logic s_hs;
  logic mismatch;

  // tvalid only rises with a free slot; full can only set via our own
  // push, so a raised tvalid cannot drop before its handshake.
  assign m00_axis_tvalid = (state_q == SEND) && !fifo_full;
  assign m00_axis_tdata  = {a_q, b_q};
  assign m00_axis_tlast  = last_q;
  assign s00_axis_tready = !fifo_empty;

  assign m_hs = m00_axis_tvalid && m00_axis_tready;
  assign s_hs = s00_axis_tvalid && s00_axis_tready;

  assign push_din.last = last_q;
  assign push_din.prod = smul(a_q, b_q);

  assign mismatch = (s00_axis_tdata != head.prod) ||
                    (s00_axis_tlast != head.last);

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

  streammult_exp_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (axis_aclk),
    .rst  (axis_areset),
    .push (m_hs),
    .pop  (s_hs),
    .din  (push_din),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    last_d  = last_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    npkts_d = npkts_q;
    err_d   = err_q;

    if (s_hs && mismatch && (err_q != 16'hFFFF))
      err_d = err_q + 16'd1;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          err_d   = '0;
          beat_d  = '0;
          pkt_d   = '0;
          npkts_d = num_pkts;
          a_d     = base_a;
          b_d     = base_b;
          last_d  = (PKT_LEN == 1);
          state_d = (num_pkts == 16'd0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (m_hs) begin
          a_d = a_q + 16'sd1;
          b_d = b_q - 16'sd1;
          if (last_q) begin
            beat_d = '0;
            pkt_d  = pkt_q + 16'd1;
            if (pkt_q == npkts_q - 16'd1)
              state_d = DRAIN;
          end else begin
            beat_d = beat_q + 16'd1;
          end
          last_d = (beat_d == 16'(PKT_LEN - 1));
        end
      end
      DRAIN: begin
        if (fifo_empty)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SEND) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_d == 16'd0);
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= 1'b0;
      beat_q  <= '0;
      pkt_q   <= '0;
      npkts_q <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      npkts_q <= npkts_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

endmodule

// File: tb/tb_streammult_tester.sv
// Loopback bench: tester drives a 3-cycle multiplier model; a scoreboard
// checks operand beats, handshake stability and FIFO-backed tready.
module tb_streammult_tester;

  localparam int PKT_LEN    = 4;
  localparam int FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        axis_areset;
  logic        start;
  logic [15:0] num_pkts;
  logic [15:0] base_a;
  logic [15:0] base_b;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic        m00_axis_tvalid;
  logic [31:0] m00_axis_tdata;
  logic        m00_axis_tlast;
  logic        m00_axis_tready;
  logic        s00_axis_tvalid;
  logic [31:0] s00_axis_tdata;
  logic        s00_axis_tlast;
  logic        s00_axis_tready;

  always #5 clk = ~clk;

  streammult_tester #(
    .C_M00_AXIS_TDATA_WIDTH(32),
    .C_S00_AXIS_TDATA_WIDTH(32),
    .PKT_LEN               (PKT_LEN),
    .FIFO_DEPTH            (FIFO_DEPTH)
  ) dut (
    .axis_aclk      (clk),
    .axis_areset    (axis_areset),
    .start          (start),
    .num_pkts       (num_pkts),
    .base_a         (base_a),
    .base_b         (base_b),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .m00_axis_tvalid(m00_axis_tvalid),
    .m00_axis_tdata (m00_axis_tdata),
    .m00_axis_tlast (m00_axis_tlast),
    .m00_axis_tready(m00_axis_tready),
    .s00_axis_tvalid(s00_axis_tvalid),
    .s00_axis_tdata (s00_axis_tdata),
    .s00_axis_tlast (s00_axis_tlast),
    .s00_axis_tready(s00_axis_tready)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    int          rdy;
  } res_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  res_t  mq[$];
  beat_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit go       = 0;
  bit bp       = 0;
  bit inj      = 0;
  int bidx     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req,
               $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic l);
    beat_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  // Multiplier model: fixed 3-cycle latency, optional random stalls.
  initial begin
    logic        mhs, shs, ml, l;
    logic [31:0] md, p;
    res_t        r;
    m00_axis_tready = 1'b0;
    s00_axis_tvalid = 1'b0;
    s00_axis_tdata  = '0;
    s00_axis_tlast  = 1'b0;
    forever begin
      @(negedge clk);
      mhs = (m00_axis_tvalid === 1'b1) && m00_axis_tready;
      shs = s00_axis_tvalid && (s00_axis_tready === 1'b1);
      md  = m00_axis_tdata;
      ml  = m00_axis_tlast;
      @(posedge clk);
      #2;
      if (mhs) begin
        p = {{16{md[31]}}, md[31:16]} * {{16{md[15]}}, md[15:0]};
        l = ml;
        if (inj && bidx == 2) p = p ^ 32'd1;
        if (inj && bidx == 3) l = 1'b0;
        bidx++;
        r.d   = p;
        r.l   = l;
        r.rdy = cyc + 3;
        mq.push_back(r);
      end
      if (shs) void'(mq.pop_front());
      if (axis_areset) begin
        mq.delete();
        bidx = 0;
      end
      if (s00_axis_tvalid && !shs && !axis_areset) begin
        s00_axis_tvalid = 1'b1;
      end else if (mq.size() > 0 && mq[0].rdy <= cyc &&
                   (!bp || $urandom_range(0, 1) == 1)) begin
        s00_axis_tvalid = 1'b1;
        s00_axis_tdata  = mq[0].d;
        s00_axis_tlast  = mq[0].l;
      end else begin
        s00_axis_tvalid = 1'b0;
      end
      m00_axis_tready = (mq.size() < 6) &&
                        (!bp || $urandom_range(0, 1) == 1);
    end
  end

  // Scoreboard / protocol monitor.
  initial begin
    int          outst;
    bit          stall;
    logic [31:0] pd;
    logic        pl;
    beat_t       e;
    outst = 0;
    stall = 0;
    pd    = '0;
    pl    = 1'b0;
    forever begin
      @(negedge clk);
      if (go) begin
        chk("s_tready_vs_occupancy", {31'd0, s00_axis_tready},
            {31'd0, outst != 0});
        chk("fifo_no_overflow", {31'd0, outst <= FIFO_DEPTH}, 32'd1);
        if (stall) begin
          chk("stall_tvalid", {31'd0, m00_axis_tvalid}, 32'd1);
          chk("stall_tdata", m00_axis_tdata, pd);
          chk("stall_tlast", {31'd0, m00_axis_tlast}, {31'd0, pl});
        end
        if (m00_axis_tvalid && m00_axis_tready) begin
          chk("beat_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("m_tdata", m00_axis_tdata, e.d);
            chk("m_tlast", {31'd0, m00_axis_tlast}, {31'd0, e.l});
          end
          outst++;
        end
        if (s00_axis_tvalid && s00_axis_tready) outst--;
        stall = m00_axis_tvalid && !m00_axis_tready;
        pd    = m00_axis_tdata;
        pl    = m00_axis_tlast;
        if (axis_areset) begin
          outst = 0;
          stall = 0;
          exp_q.delete();
        end
      end
    end
  end

  task automatic pulse_start(input logic [15:0] np, input logic [15:0] a,
                             input logic [15:0] b);
    @(posedge clk);
    #1;
    num_pkts = np;
    base_a   = a;
    base_b   = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    chk({nm, "_all_beats_sent"}, exp_q.size(), 32'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_tvalid"}, {31'd0, m00_axis_tvalid}, 32'd0);
    chk({nm, "_tdata"}, m00_axis_tdata, 32'd0);
    chk({nm, "_tlast"}, {31'd0, m00_axis_tlast}, 32'd0);
    chk({nm, "_s_tready"}, {31'd0, s00_axis_tready}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, done}, 32'd0);
    chk({nm, "_pass"}, {31'd0, pass}, 32'd0);
    chk({nm, "_err"}, {16'd0, err_count}, 32'd0);
  endtask

  task automatic push_basic();
    push_exp(32'h0003_0005, 1'b0);
    push_exp(32'h0004_0004, 1'b0);
    push_exp(32'h0005_0003, 1'b0);
    push_exp(32'h0006_0002, 1'b1);
  endtask

  task automatic push_wrap();
    push_exp(32'h7FFF_0002, 1'b0);
    push_exp(32'h8000_0001, 1'b0);
    push_exp(32'h8001_0000, 1'b0);
    push_exp(32'h8002_FFFF, 1'b1);
  endtask

  initial begin
    logic [15:0] a, b;
    axis_areset = 1'b1;
    start       = 1'b0;
    num_pkts    = '0;
    base_a      = '0;
    base_b      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk);
    #1;
    axis_areset = 1'b0;
    go          = 1;

    // Basic loopback
    push_basic();
    pulse_start(16'd1, 16'd3, 16'd5);
    @(negedge clk);
    chk("first_tvalid", {31'd0, m00_axis_tvalid}, 32'd1);
    chk("busy_in_send", {31'd0, busy}, 32'd1);
    wait_done("basic", 500);
    chk("basic_pass", {31'd0, pass}, 32'd1);
    chk("basic_err", {16'd0, err_count}, 32'd0);

    // Operand wrap at 0x7FFF
    push_wrap();
    pulse_start(16'd1, 16'h7FFF, 16'd2);
    wait_done("wrap", 500);
    chk("wrap_pass", {31'd0, pass}, 32'd1);
    chk("wrap_err", {16'd0, err_count}, 32'd0);

    // Error injection: data flip on beat 2, tlast dropped on beat 3
    bidx = 0;
    inj  = 1;
    push_basic();
    pulse_start(16'd1, 16'd3, 16'd5);
    wait_done("inject", 500);
    chk("inject_err", {16'd0, err_count}, 32'd2);
    chk("inject_pass", {31'd0, pass}, 32'd0);
    inj = 0;

    // Backpressure on both sides
    bp = 1;
    for (int k = 0; k < 5 * PKT_LEN; k++) begin
      a = 16'h1234 + 16'(k);
      b = 16'hFFF0 - 16'(k);
      push_exp({a, b}, (k % PKT_LEN) == PKT_LEN - 1);
    end
    pulse_start(16'd5, 16'h1234, 16'hFFF0);
    wait_done("bp", 3000);
    chk("bp_pass", {31'd0, pass}, 32'd1);
    chk("bp_err", {16'd0, err_count}, 32'd0);
    bp = 0;

    // Zero-packet run
    pulse_start(16'd0, 16'd9, 16'd9);
    @(negedge clk);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_pass", {31'd0, pass}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_no_tvalid", {31'd0, m00_axis_tvalid}, 32'd0);

    // Start while busy must be ignored
    push_basic();
    pulse_start(16'd1, 16'd3, 16'd5);
    pulse_start(16'd0, 16'd100, 16'd100);
    @(negedge clk);
    chk("restart_ignored_busy", {31'd0, busy}, 32'd1);
    wait_done("restart", 500);
    chk("restart_pass", {31'd0, pass}, 32'd1);

    // Reset in the middle of SEND
    for (int k = 0; k < 2 * PKT_LEN; k++) begin
      a = 16'd3 + 16'(k);
      b = 16'd5 - 16'(k);
      push_exp({a, b}, (k % PKT_LEN) == PKT_LEN - 1);
    end
    pulse_start(16'd2, 16'd3, 16'd5);
    @(posedge clk);
    #1;
    axis_areset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("midrst");
    @(posedge clk);
    #1;
    axis_areset = 1'b0;
    push_wrap();
    pulse_start(16'd1, 16'h7FFF, 16'd2);
    wait_done("postrst", 500);
    chk("postrst_pass", {31'd0, pass}, 32'd1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/streammult_tester.md
# streammult_tester

AXI-Stream traffic generator and result checker for the stream multiplier. The master port emits packets of packed signed 16-bit operand pairs ({a,b} in tdata[31:16]/[15:0]) with tlast. The slave port consumes the 32-bit product stream returned by the multiplier and compares each beat against a locally computed expected product. It sits on the opposite side of both of the multiplier's stream ports, for self-test and bring-up.

## Interface
- C_M00_AXIS_TDATA_WIDTH, 32, operand stream width; fixed at 32.
- C_S00_AXIS_TDATA_WIDTH, 32, result stream width; fixed at 32.
- PKT_LEN, 8, beats per packet; ≥1.
- FIFO_DEPTH, 4, expected-result FIFO entries; power of 2, ≥2.

Ports:
- axis_aclk  in  1  single clock for both stream ports.
- axis_areset  in  1  synchronous, active-high reset. Clock and reset are fixed as one clock; reset is synchronous and active-high.
- start  in  1  one-cycle pulse that starts a run; ignored unless the state is IDLE or DONE.
- num_pkts  in  16  packets per run, sampled on start.
- base_a, base_b  in  16 each  signed starting operands, sampled on start.
- busy  out  1  high in SEND and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  done && err_count==0.
- err_count  out  16  mismatching beats; saturates at 0xFFFF.
- m00_axis_tvalid / m00_axis_tdata[31:0] / m00_axis_tlast  out; m00_axis_tready  in.
- s00_axis_tvalid / s00_axis_tdata[31:0] / s00_axis_tlast  in; s00_axis_tready  out.

## Operation
- FSM states and transitions:
  - IDLE → SEND on start.
  - IDLE → DONE on start when num_pkts==0.
  - SEND → DRAIN on the handshake of the final beat.
  - DRAIN → DONE when the FIFO is empty.
  - DONE → SEND/DONE on a new start, same rules as from IDLE.
- start, in both IDLE and DONE: clears err_count and the beat/packet counters, and latches num_pkts, base_a and base_b.
- Beat k of the run (k=0..num_pkts*PKT_LEN-1):
  - a_k = base_a+k and b_k = base_b−k, both mod 2^16 (wrap, no saturation).
  - tdata = {a_k, b_k}.
  - tlast=1 iff (k mod PKT_LEN)==PKT_LEN−1.
- Master handshake:
  - tvalid may rise only in SEND and only while the FIFO is not full.
  - Once raised, tvalid, tdata and tlast hold stable until tready.
  - The beat advances only on tvalid&&tready.
- On each master handshake, push {tlast, a_k*b_k} into the FIFO. The product is a signed 16×16→32 multiply, full precision.
- s00_axis_tready = FIFO not empty, registered or combinational from FIFO state, with no dependence on s00_axis_tvalid.
- On each slave handshake:
  - Pop the FIFO head.
  - A mismatch is tdata≠head.product or tlast≠head.tlast; on mismatch, err_count += 1 (saturating).
- Simultaneous push and pop on a full FIFO is not possible, since push requires not-full at tvalid rise. Simultaneous push and pop at any other occupancy is legal; occupancy is unchanged.
- Extra slave beats in IDLE/DONE are not accepted (tready=0).

## Timing
- Reset values:
  - state = IDLE.
  - m00_axis_tvalid, tlast = 0; tdata = 0.
  - s00_axis_tready = 0.
  - busy, done, pass = 0; err_count = 0.
  - FIFO empty.
- First m00_axis_tvalid is asserted the cycle after start.
- With tready held high and a FIFO slot free, one beat per cycle.
- done asserts the cycle after the FIFO goes empty in DRAIN. done and pass hold until the next start or reset.
- Reset mid-run: all state returns to reset values on the next edge, and the FIFO is flushed. The downstream multiplier must be reset together.

## Structure
- Package streammult_pkg: state enum (IDLE, SEND, DRAIN, DONE), OPW=16, PRODW=32, and the FIFO entry struct {logic last; logic signed [31:0] prod}.
- Sub-module streammult_exp_fifo:
  - Synchronous FIFO, FIFO_DEPTH × 33 bits.
  - Ports: push, pop, full, empty, din, dout (first-word-fall-through).
  - Pointers carry one extra wrap bit.
- Top level: FSM, beat/packet counters, operand generator, comparator, error counter.

## Test plan
- Loopback through a 3-cycle multiplier model; PKT_LEN=4, num_pkts=1, base_a=3, base_b=5 → m00 beats {3,5},{4,4},{5,3},{6,2} with tlast on beat 3; products 15,16,15,12 accepted; done=1, pass=1, err_count=0.
- Wrap: base_a=0x7FFF, base_b=2 → beat 1 is a=0x8000 (−32768), b=1, expected product 0xFFFF8000; the checker matches it.
- Error injection: corrupt the result of beat 2 (tdata ^ 1) and force tlast=0 on the packet's last result → err_count=2, pass=0.
- Backpressure: random m00_axis_tready and s00_axis_tvalid, FIFO_DEPTH=2, num_pkts=5 → tvalid/tdata never change while stalled; FIFO never overflows; err_count=0.
- num_pkts=0 → no m00 beat; DONE the cycle after start with pass=1; a second start during busy is ignored.
- Reset asserted mid-SEND → next cycle all outputs at reset values; a new run completes with pass=1.
